// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator: operation codes and FSM states.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle over WIDTH cycles.
// quotient/remainder/done present the outcome of the step taken on the coming edge.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             active;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_next, quo_next;

  // The step depends only on registered partial remainder/quotient: one WIDTH+1-bit subtract.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (trial[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign quotient  = quo_next;
  assign remainder = rem_next;
  assign done      = active && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      count  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
    end else if (active) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      count <= count + CW'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_calculator.sv
// Handshaked unsigned add/sub/mul/div unit; divide is delegated to a multi-cycle divider.
// state | meaning: IDLE accepting ops | DIV divider iterating | DONE result held for consumer
module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               divide_by_zero,
  output logic               busy
);

  state_t state, state_next;

  logic               accept, div_start, div_done;
  logic [WIDTH-1:0]   quotient, remainder;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] product, alu_result;

  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (op == OP_DIV) && (B != '0);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (A),
    .divisor  (B),
    .quotient (quotient),
    .remainder(remainder),
    .done     (div_done)
  );

  assign sum     = {1'b0, A} + {1'b0, B};
  assign diff    = {1'b0, A} - {1'b0, B};
  assign product = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // Single-cycle results, captured straight from the operands at accept.
  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = {{(WIDTH-1){1'b0}}, sum};
      OP_SUB:  alu_result = {{(WIDTH-1){diff[WIDTH]}}, diff};
      OP_MUL:  alu_result = product;
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = div_start ? DIV : DONE;
      DIV:     if (div_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      result         <= '0;
      divide_by_zero <= 1'b0;
    end else if (accept && !div_start) begin
      out_valid      <= 1'b1;
      result         <= alu_result;
      divide_by_zero <= (op == OP_DIV);
    end else if ((state == DIV) && div_done) begin
      out_valid      <= 1'b1;
      result         <= {remainder, quotient};
      divide_by_zero <= 1'b0;
    end else if ((state == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed and randomized checks of seq_calculator at WIDTH 4, 8 and 16.
module tb_seq_calculator;

  logic clk = 1'b0;
  logic rst;
  logic out_ready;
  logic [15:0] A_d, B_d;
  logic [1:0]  op_d;
  logic ivalid[3];
  logic iready[3];
  logic ovalid[3];
  logic dbz_w[3];
  logic busy_w[3];
  logic [7:0]  r4;
  logic [15:0] r8;
  logic [31:0] r16;
  logic [31:0] res_w[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign res_w[0] = {24'b0, r4};
  assign res_w[1] = {16'b0, r8};
  assign res_w[2] = r16;

  seq_calculator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(ivalid[0]), .in_ready(iready[0]),
    .A(A_d[3:0]), .B(B_d[3:0]), .op(op_d), .out_valid(ovalid[0]),
    .out_ready(out_ready), .result(r4), .divide_by_zero(dbz_w[0]), .busy(busy_w[0]));

  seq_calculator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(ivalid[1]), .in_ready(iready[1]),
    .A(A_d[7:0]), .B(B_d[7:0]), .op(op_d), .out_valid(ovalid[1]),
    .out_ready(out_ready), .result(r8), .divide_by_zero(dbz_w[1]), .busy(busy_w[1]));

  seq_calculator #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(ivalid[2]), .in_ready(iready[2]),
    .A(A_d), .B(B_d), .op(op_d), .out_valid(ovalid[2]),
    .out_ready(out_ready), .result(r16), .divide_by_zero(dbz_w[2]), .busy(busy_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arithmetic definition of each operation, independent of any hardware structure.
  function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] o, output logic dz);
    longint unsigned opmask, resmask, x, y, r;
    opmask  = (64'd1 << w) - 1;
    resmask = (64'd1 << (2 * w)) - 1;
    x = longint'(a) & opmask;
    y = longint'(b) & opmask;
    dz = 1'b0;
    case (o)
      2'd0: r = x + y;
      2'd1: r = (x - y) & resmask;
      2'd2: r = x * y;
      default: begin
        if (y == 0) begin r = 0; dz = 1'b1; end
        else r = ((x % y) << w) | (x / y);
      end
    endcase
    return r[31:0];
  endfunction

  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] o, input int hold, input logic [31:0] exp_res,
                       input logic exp_dz, input string tag);
    int n, w, exp_lat;
    w = (sel == 0) ? 4 : (sel == 1) ? 8 : 16;
    exp_lat = (o == 2'd3 && model(w, b, 16'd0, 2'd0, exp_dz) != 0) ? w + 1 : 1;
    exp_dz = (o == 2'd3 && exp_lat == 1);
    n = 0;
    while (!iready[sel] && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "_ready"}, iready[sel], 1);
    A_d = a; B_d = b; op_d = o; ivalid[sel] = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    ivalid[sel] = 1'b0;
    A_d = 16'($urandom); B_d = 16'($urandom); op_d = 2'($urandom);
    n = 1;
    while (!ovalid[sel] && n < 40) begin
      check({tag, "_inflight"}, {busy_w[sel], iready[sel]}, 2'b10);
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, res_w[sel], exp_res);
    check({tag, "_dbz"}, dbz_w[sel], exp_dz);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {ovalid[sel], iready[sel], dbz_w[sel]}, {2'b10, exp_dz});
      check({tag, "_hold_res"}, res_w[sel], exp_res);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_handoff"}, {ovalid[sel], iready[sel]}, 2'b01);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [1:0]  ro;
    logic        rdz;
    logic [31:0] rexp;
    int seen;

    rst = 1'b1; out_ready = 1'b0;
    A_d = '0; B_d = '0; op_d = '0;
    for (int i = 0; i < 3; i++) ivalid[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_ctrl", {iready[i], ovalid[i], busy_w[i], dbz_w[i]}, 4'b0000);
      check("reset_result", res_w[i], 0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_reset", {iready[0], iready[1], iready[2]}, 3'b111);

    // WIDTH=8 directed cases
    do_op(1, 200, 100, 2'd0, 0, 32'h012C, 1'b0, "add200_100");
    do_op(1, 3,   5,   2'd1, 0, 32'hFFFE, 1'b0, "sub3_5");
    do_op(1, 255, 255, 2'd2, 0, 32'hFE01, 1'b0, "mul255_255");
    do_op(1, 200, 7,   2'd3, 0, 32'h041C, 1'b0, "div200_7");
    do_op(1, 8,   0,   2'd3, 0, 32'h0000, 1'b1, "div8_0");
    do_op(1, 3,   2,   2'd0, 0, 32'h0005, 1'b0, "add3_2");
    do_op(1, 12,  12,  2'd2, 5, 32'h0090, 1'b0, "mul12_12_bp");
    do_op(1, 0,   255, 2'd1, 0, 32'hFF01, 1'b0, "sub0_255");
    do_op(1, 255, 255, 2'd3, 0, 32'h0001, 1'b0, "div255_255");

    // Reset during the 4th divide cycle of 255/1
    A_d = 255; B_d = 1; op_d = 2'd3; ivalid[1] = 1'b1;
    @(posedge clk); #1;
    ivalid[1] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_busy", busy_w[1], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_in_reset", {iready[1], ovalid[1], busy_w[1]}, 3'b000);
    check("abort_result", res_w[1], 0);
    rst = 1'b0;
    #1;
    check("abort_ready", iready[1], 1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ovalid[1]) seen++;
    end
    check("abort_no_stale", seen, 0);
    do_op(1, 9, 3, 2'd3, 0, 32'h0003, 1'b0, "div9_3");

    // WIDTH=4 regression
    do_op(0, 3, 2, 2'd0, 0, 32'h05, 1'b0, "w4_add");
    do_op(0, 5, 3, 2'd1, 0, 32'h02, 1'b0, "w4_sub");
    do_op(0, 2, 4, 2'd2, 0, 32'h08, 1'b0, "w4_mul");
    do_op(0, 8, 2, 2'd3, 0, 32'h04, 1'b0, "w4_div");
    do_op(0, 8, 0, 2'd3, 1, 32'h00, 1'b1, "w4_div0");
    do_op(0, 3, 5, 2'd1, 0, 32'hFE, 1'b0, "w4_subneg");

    // WIDTH=16 randomized sweep against the arithmetic model
    for (int k = 0; k < 30; k++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      ro = 2'($urandom);
      rexp = model(16, ra, rb, ro, rdz);
      do_op(2, ra, rb, ro, int'($urandom_range(0, 2)), rexp, rdz, "w16_rand");
    end
    do_op(2, 16'hFFFF, 16'hFFFF, 2'd2, 0, 32'hFFFE0001, 1'b0, "w16_mulmax");
    do_op(2, 16'h0000, 16'hFFFF, 2'd1, 0, 32'hFFFF0001, 1'b0, "w16_submin");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule
